// File: rtl/sys_arr_pkg.sv
// Shared systolic-array constants and types used by the GSAU writeback path.
package sys_arr_pkg;

  localparam int GSAU_PSUM_W    = 512;
  localparam int GSAU_RF_BEAT_W = 128;
  localparam int GSAU_WB_DEPTH  = 4;
  localparam int GSAU_DST_W     = 8;

  typedef struct packed {
    logic [GSAU_PSUM_W-1:0] psum;
    logic [GSAU_DST_W-1:0]  vdst;
  } wb_entry_t;

  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/gsau_wb_buffer_fifo.sv
// Circular FIFO of writeback entries; head is the oldest entry, storage carries no reset.
module wb_entry_fifo
  import sys_arr_pkg::*;
#(
  parameter int  DEPTH   = GSAU_WB_DEPTH,
  parameter type ENTRY_T = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  ENTRY_T           data_i,
  input  logic             pop_i,
  output ENTRY_T           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  ENTRY_T           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer: queues psum rows and drains them beat-wise to the VRF write port.
// Optional GSAU_WB_STALL_CNT_EN adds a saturating stall counter output.
//   state    | meaning
//   WB_IDLE  | no request; leave when an entry is buffered
//   WB_WRITE | requesting head entry beat; pop after the last beat commits
module gsau_wb_buffer
  import sys_arr_pkg::*;
#(
  parameter int  DEPTH  = GSAU_WB_DEPTH,
  parameter int  DATA_W = GSAU_PSUM_W,
  parameter int  BEAT_W = GSAU_RF_BEAT_W,
  parameter int  DST_W  = GSAU_DST_W,
  localparam int BEATS  = DATA_W / BEAT_W,
  localparam int BI_W   = $clog2(BEATS),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_psum,
  input  logic [DST_W-1:0]  wb_wbdst,
  output logic              wb_output_ready,
  output logic              rf_wr_req,
  input  logic              rf_wr_gnt,
  output logic [DST_W-1:0]  rf_wr_vdst,
  output logic [BI_W-1:0]   rf_wr_beat,
  output logic [BEAT_W-1:0] rf_wr_data,
  output logic              sb_done_valid,
  output logic [DST_W-1:0]  sb_done_vdst,
`ifdef GSAU_WB_STALL_CNT_EN
  output logic [31:0]       wb_stall_cycles,
`endif
  output logic [CNT_W-1:0]  buf_count,
  output logic              buf_empty
);

  typedef struct packed {
    logic [DATA_W-1:0] psum;
    logic [DST_W-1:0]  vdst;
  } entry_t;

  entry_t           wr_entry, head;
  logic             full, empty, push, pop, last_beat;
  logic [CNT_W-1:0] count;
  wb_state_t        state_q, state_d;
  logic [BI_W-1:0]  beat_q, beat_d;
  logic             done_valid_q;
  logic [DST_W-1:0] done_vdst_q;

  // No bypass: readiness comes from the registered count only.
  assign wb_output_ready = !full;
  assign push            = wb_valid && !full;
  assign last_beat       = (beat_q == BI_W'(BEATS - 1));
  assign pop             = (state_q == WB_WRITE) && rf_wr_gnt && last_beat;
  assign wr_entry        = '{psum: wb_psum, vdst: wb_wbdst};

  wb_entry_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    rf_wr_req  = 1'b0;
    rf_wr_vdst = '0;
    rf_wr_beat = '0;
    rf_wr_data = '0;
    case (state_q)
      WB_IDLE: begin
        if (count != '0) begin
          state_d = WB_WRITE;
          beat_d  = '0;
        end
      end
      WB_WRITE: begin
        rf_wr_req  = 1'b1;
        rf_wr_vdst = head.vdst;
        rf_wr_beat = beat_q;
        rf_wr_data = head.psum[int'(beat_q)*BEAT_W +: BEAT_W];
        if (rf_wr_gnt) begin
          if (!last_beat) begin
            beat_d = beat_q + BI_W'(1);
          end else begin
            beat_d  = '0;
            state_d = (count > CNT_W'(1)) ? WB_WRITE : WB_IDLE;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= WB_IDLE;
      beat_q       <= '0;
      done_valid_q <= 1'b0;
      done_vdst_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      done_valid_q <= pop;
      if (pop) done_vdst_q <= head.vdst;
    end
  end

  assign sb_done_valid = done_valid_q;
  assign sb_done_vdst  = done_vdst_q;
  assign buf_count     = count;
  assign buf_empty     = empty;

`ifdef GSAU_WB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [1:0]  stall_inc;

  always_comb begin
    stall_inc = 2'(rf_wr_req && !rf_wr_gnt) + 2'(wb_valid && !wb_output_ready);
    if (stall_q > 32'hFFFF_FFFF - 32'(stall_inc)) stall_d = 32'hFFFF_FFFF;
    else                                          stall_d = stall_q + 32'(stall_inc);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign wb_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Directed testbench for gsau_wb_buffer with hand-computed expectations.
module tb_gsau_wb_buffer;

  logic         CLK;
  logic         nRST;
  logic         wb_valid;
  logic [511:0] wb_psum;
  logic [7:0]   wb_wbdst;
  logic         wb_output_ready;
  logic         rf_wr_req;
  logic         rf_wr_gnt;
  logic [7:0]   rf_wr_vdst;
  logic [1:0]   rf_wr_beat;
  logic [127:0] rf_wr_data;
  logic         sb_done_valid;
  logic [7:0]   sb_done_vdst;
  logic [2:0]   buf_count;
  logic         buf_empty;
`ifdef GSAU_WB_STALL_CNT_EN
  logic [31:0]  wb_stall_cycles;
`endif

  gsau_wb_buffer dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .wb_valid        (wb_valid),
    .wb_psum         (wb_psum),
    .wb_wbdst        (wb_wbdst),
    .wb_output_ready (wb_output_ready),
    .rf_wr_req       (rf_wr_req),
    .rf_wr_gnt       (rf_wr_gnt),
    .rf_wr_vdst      (rf_wr_vdst),
    .rf_wr_beat      (rf_wr_beat),
    .rf_wr_data      (rf_wr_data),
    .sb_done_valid   (sb_done_valid),
    .sb_done_vdst    (sb_done_vdst),
`ifdef GSAU_WB_STALL_CNT_EN
    .wb_stall_cycles (wb_stall_cycles),
`endif
    .buf_count       (buf_count),
    .buf_empty       (buf_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int got_n;
  logic [7:0] got_vdst [16];
  int         got_cyc  [16];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic logic [511:0] mk_psum(input logic [7:0] v);
    logic [511:0] p;
    for (int j = 0; j < 4; j++) p[j*128 +: 128] = {v, 56'h0, 32'hC0DE_0000, 24'h0, 8'(j)};
    return p;
  endfunction

  task automatic push_set(input logic [7:0] v);
    wb_valid = 1'b1;
    wb_wbdst = v;
    wb_psum  = mk_psum(v);
  endtask

  // Runs ncyc cycles, checking every committed beat's payload and logging done pulses.
  task automatic drain(input int ncyc);
    logic [511:0] p;
    got_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (rf_wr_req && rf_wr_gnt) begin
        p = mk_psum(rf_wr_vdst);
        chk("beat_data", 512'(rf_wr_data), 512'(p[int'(rf_wr_beat)*128 +: 128]));
      end
      if (sb_done_valid) begin
        if (got_n < 16) begin
          got_vdst[got_n] = sb_done_vdst;
          got_cyc[got_n]  = cyc;
        end
        got_n++;
      end
      tick();
    end
  endtask

  logic [511:0] p1;
  logic [127:0] s_base;
  logic         gp [7];
  int           eb [7];

  initial begin
    nRST = 1'b0; wb_valid = 1'b0; wb_psum = '0; wb_wbdst = '0; rf_wr_gnt = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    chk("rst_req",   512'(rf_wr_req), 512'(0));
    chk("rst_count", 512'(buf_count), 512'(0));
    chk("rst_empty", 512'(buf_empty), 512'(1));
    chk("rst_ready", 512'(wb_output_ready), 512'(1));
    chk("rst_done",  512'(sb_done_valid), 512'(0));

    // Test 1: single entry, grant held.
    s_base = 128'hAAAA_AAAA_AAAA_AAAA_0000_0000_0000_0000;
    for (int j = 0; j < 4; j++) p1[j*128 +: 128] = s_base | 128'(j + 1);
    wb_valid = 1'b1; wb_psum = p1; wb_wbdst = 8'h12; rf_wr_gnt = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("t1_req_n1",   512'(rf_wr_req), 512'(0));
    chk("t1_count_n1", 512'(buf_count), 512'(1));
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("t1_req",  512'(rf_wr_req),  512'(1));
      chk("t1_beat", 512'(rf_wr_beat), 512'(b));
      chk("t1_vdst", 512'(rf_wr_vdst), 512'(8'h12));
      chk("t1_data", 512'(rf_wr_data), 512'(s_base | 128'(b + 1)));
      chk("t1_nodone", 512'(sb_done_valid), 512'(0));
      tick();
    end
    chk("t1_done",      512'(sb_done_valid), 512'(1));
    chk("t1_done_vdst", 512'(sb_done_vdst),  512'(8'h12));
    chk("t1_req_idle",  512'(rf_wr_req),     512'(0));
    tick();
    chk("t1_done_once", 512'(sb_done_valid), 512'(0));

    // Test 2: fill to full with grant low, then release.
    rf_wr_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_set(8'(k));
      tick();
    end
    push_set(8'd5);
    chk("t2_ready_full", 512'(wb_output_ready), 512'(0));
    chk("t2_count_full", 512'(buf_count), 512'(4));
    tick();
    chk("t2_held_count", 512'(buf_count), 512'(4));
    tick();
    chk("t2_held_ready", 512'(wb_output_ready), 512'(0));
    rf_wr_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_low", 512'(wb_output_ready), 512'(0));
      tick();
    end
    chk("t2_ready_rise", 512'(wb_output_ready), 512'(1));
    chk("t2_done1",      512'(sb_done_valid), 512'(1));
    chk("t2_done1_vdst", 512'(sb_done_vdst), 512'(1));
    chk("t2_count3",     512'(buf_count), 512'(3));
    tick();
    wb_valid = 1'b0;
    chk("t2_count_after_push", 512'(buf_count), 512'(4));
    drain(40);
    chk("t2_ndone", 512'(got_n), 512'(4));
    for (int i = 0; i < 4; i++) chk("t2_order", 512'(got_vdst[i]), 512'(i + 2));

    // Test 3: grant stalls (reset first so the stall counter starts from zero).
    nRST = 1'b0; rf_wr_gnt = 1'b0;
    tick();
    nRST = 1'b1;
    push_set(8'h33);
    tick();
    wb_valid = 1'b0;
    tick();
    gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    eb = '{0, 1, 1, 1, 2, 2, 3};
    p1 = mk_psum(8'h33);
    for (int i = 0; i < 7; i++) begin
      rf_wr_gnt = gp[i];
      chk("t3_req",  512'(rf_wr_req),  512'(1));
      chk("t3_beat", 512'(rf_wr_beat), 512'(eb[i]));
      chk("t3_vdst", 512'(rf_wr_vdst), 512'(8'h33));
      chk("t3_data", 512'(rf_wr_data), 512'(p1[eb[i]*128 +: 128]));
      tick();
    end
    rf_wr_gnt = 1'b0;
    chk("t3_done",      512'(sb_done_valid), 512'(1));
    chk("t3_done_vdst", 512'(sb_done_vdst),  512'(8'h33));
    chk("t3_req_idle",  512'(rf_wr_req),     512'(0));
`ifdef GSAU_WB_STALL_CNT_EN
    chk("t3_stall_cnt", 512'(wb_stall_cycles), 512'(3));
`endif
    tick();

    // Test 4: push coinciding with final-beat pop; write pointer wraps 3 -> 0.
    push_set(8'h41);
    tick();
    push_set(8'h42);
    tick();
    wb_valid = 1'b0; rf_wr_gnt = 1'b1;
    chk("t4_req",    512'(rf_wr_req), 512'(1));
    chk("t4_count2", 512'(buf_count), 512'(2));
    tick(); tick(); tick();
    chk("t4_last_beat", 512'(rf_wr_beat), 512'(3));
    chk("t4_last_vdst", 512'(rf_wr_vdst), 512'(8'h41));
    push_set(8'h43);
    tick();
    wb_valid = 1'b0;
    chk("t4_count_same", 512'(buf_count),   512'(2));
    chk("t4_b2b_req",    512'(rf_wr_req),   512'(1));
    chk("t4_b2b_beat",   512'(rf_wr_beat),  512'(0));
    chk("t4_b2b_vdst",   512'(rf_wr_vdst),  512'(8'h42));
    chk("t4_doneA",      512'(sb_done_valid), 512'(1));
    chk("t4_doneA_vdst", 512'(sb_done_vdst),  512'(8'h41));
    push_set(8'h44);
    tick();
    wb_valid = 1'b0;
    chk("t4_count3", 512'(buf_count), 512'(3));
    drain(30);
    chk("t4_ndone", 512'(got_n), 512'(3));
    for (int i = 0; i < 3; i++) chk("t4_order", 512'(got_vdst[i]), 512'(8'h42 + i));

    // Test 5: reset during beat 2.
    push_set(8'h07);
    tick();
    wb_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5_beat2", 512'(rf_wr_beat), 512'(2));
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk("t5_req",   512'(rf_wr_req),       512'(0));
    chk("t5_count", 512'(buf_count),       512'(0));
    chk("t5_done",  512'(sb_done_valid),   512'(0));
    chk("t5_ready", 512'(wb_output_ready), 512'(1));
    tick();
    chk("t5_no_late_done", 512'(sb_done_valid), 512'(0));
    chk("t5_idle",         512'(rf_wr_req),     512'(0));
    push_set(8'h08);
    tick();
    wb_valid = 1'b0;
    drain(12);
    chk("t5_fresh_ndone", 512'(got_n), 512'(1));
    chk("t5_fresh_vdst",  512'(got_vdst[0]), 512'(8'h08));

    // Test 6: duplicate destinations.
    push_set(8'h20);
    tick();
    push_set(8'h20);
    tick();
    wb_valid = 1'b0;
    drain(20);
    chk("t6_ndone", 512'(got_n), 512'(2));
    chk("t6_vdst0", 512'(got_vdst[0]), 512'(8'h20));
    chk("t6_vdst1", 512'(got_vdst[1]), 512'(8'h20));
    chk("t6_gap",   512'(got_cyc[1] - got_cyc[0] >= 4), 512'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
